// File: rtl/alu_seq.sv
// Registered ALU with a valid/ready handshake: single-cycle logic, arithmetic,
// compare and shift ops, plus iterative (one bit per cycle) unsigned MULU/DIVU.
module alu_seq #(
    parameter int  WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Op,
    output logic             Out_valid,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Carryout,
    output logic             Overflow,
    output logic             Zero,
    output logic             Set
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_MULU = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             set_q, set_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic             sc_ovf;
    logic             sc_set;
    logic             sc_legal;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_trial;
    logic [WIDTH-1:0] it_hi;
    logic [WIDTH-1:0] it_lo;

    assign In_ready  = (state_q == S_IDLE);
    assign Out_valid = (state_q == S_DONE);
    assign Result    = result_q;
    assign ResultHi  = result_hi_q;
    assign Carryout  = carry_q;
    assign Overflow  = ovf_q;
    assign Zero      = zero_q;
    assign Set       = set_q;

    // Single-cycle datapath, evaluated straight from the input operands.
    always_comb begin
        shamt    = B[SHW-1:0];
        add_full = {1'b0, A} + {1'b0, B};
        sub_full = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_set   = 1'b0;
        sc_legal = 1'b1;
        case (Op)
            OP_AND: sc_res = A & B;
            OP_OR:  sc_res = A | B;
            OP_XOR: sc_res = A ^ B;
            OP_ADD: begin
                sc_res   = add_full[WIDTH-1:0];
                sc_carry = add_full[WIDTH];
                sc_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = sub_full[WIDTH-1:0];
                sc_carry = sub_full[WIDTH];
                sc_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_full[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: begin
                sc_set = ($signed(A) < $signed(B));
                sc_res = {{(WIDTH-1){1'b0}}, sc_set};
            end
            OP_SLTU: begin
                sc_set = (A < B);
                sc_res = {{(WIDTH-1){1'b0}}, sc_set};
            end
            OP_SLL: sc_res = A << shamt;
            OP_SRL: sc_res = A >> shamt;
            OP_SRA: sc_res = $unsigned($signed(A) >>> shamt);
            default: sc_legal = 1'b0;
        endcase
    end

    // One MULU/DIVU iteration. hi/lo hold {partial product, multiplier} for
    // MULU and {remainder, dividend->quotient} for DIVU. A zero divisor never
    // borrows, so the quotient fills with ones and the remainder ends as A.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
        it_hi     = mul_sum[WIDTH:1];
        it_lo     = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (is_div_q) begin
            if (div_trial[WIDTH+1]) begin
                it_hi = div_shift[WIDTH-1:0];
                it_lo = {lo_q[WIDTH-2:0], 1'b0};
            end else begin
                it_hi = div_trial[WIDTH-1:0];
                it_lo = {lo_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        div0_d      = div0_q;
        opnd_d      = opnd_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        set_d       = set_q;
        case (state_q)
            S_IDLE: begin
                if (In_valid) begin
                    if (Op == OP_MULU || Op == OP_DIVU) begin
                        state_d  = S_BUSY;
                        cnt_d    = '0;
                        hi_d     = '0;
                        is_div_d = (Op == OP_DIVU);
                        div0_d   = (Op == OP_DIVU) && (B == '0);
                        opnd_d   = (Op == OP_DIVU) ? B : A;
                        lo_d     = (Op == OP_DIVU) ? A : B;
                    end else begin
                        state_d     = S_DONE;
                        result_d    = sc_res;
                        result_hi_d = '0;
                        carry_d     = sc_carry;
                        ovf_d       = sc_ovf;
                        set_d       = sc_set;
                        zero_d      = sc_legal && (sc_res == '0);
                    end
                end
            end
            S_BUSY: begin
                hi_d  = it_hi;
                lo_d  = it_lo;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH-1)) begin
                    state_d     = S_DONE;
                    result_d    = it_lo;
                    result_hi_d = it_hi;
                    carry_d     = 1'b0;
                    set_d       = 1'b0;
                    ovf_d       = is_div_q ? div0_q : (it_hi != '0);
                    zero_d      = (it_lo == '0);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            div0_q      <= 1'b0;
            opnd_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            set_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            div0_q      <= div0_d;
            opnd_q      <= opnd_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            set_q       <= set_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a 32-bit and an 8-bit instance, directed and
// random ops checked against an arithmetic reference model.
module tb_alu_seq;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        c;
        logic        v;
        logic        z;
        logic        s;
        int          acc;
        int          lat;
    } exp_t;

    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_MULU = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;

    logic clk = 1'b0;
    int   cyc = 0;

    logic        rst32, v32, rdy32, ov32, c32, o32, z32, s32;
    logic [31:0] a32, b32, r32, h32;
    logic [3:0]  op32;
    logic        rst8, v8, rdy8, ov8, c8, o8, z8, s8;
    logic [7:0]  a8, b8, r8, h8;
    logic [3:0]  op8;

    exp_t sb32[$];
    exp_t sb8[$];
    exp_t me;
    int   compared = 0;
    int   mismatched = 0;
    int   ntx = 0;
    logic chk_reset32, chk_reset8, chk_busy32;
    logic [67:0] last32, now32, want32;
    logic [19:0] last8, now8, want8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(rst32), .In_valid(v32), .In_ready(rdy32),
        .A(a32), .B(b32), .Op(op32), .Out_valid(ov32), .Result(r32),
        .ResultHi(h32), .Carryout(c32), .Overflow(o32), .Zero(z32), .Set(s32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst8), .In_valid(v8), .In_ready(rdy8),
        .A(a8), .B(b8), .Op(op8), .Out_valid(ov8), .Result(r8),
        .ResultHi(h8), .Carryout(c8), .Overflow(o8), .Zero(z8), .Set(s8)
    );

    function automatic exp_t mk(input logic [31:0] r, input logic [31:0] h,
                                input logic c, input logic v, input logic z,
                                input logic s, input int lat);
        exp_t e;
        e.res = r; e.hi = h; e.c = c; e.v = v; e.z = z; e.s = s;
        e.acc = 0; e.lat = lat;
        return e;
    endfunction

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic exp_t model(input int w, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint unsigned m, ua, ub, r, p;
        longint sa, sb, t, half;
        int amt;
        bit legal;
        e = mk(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        m    = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & m;
        ub   = {32'd0, b} & m;
        half = longint'(64'd1 << (w - 1));
        sa   = (longint'(ua) >= half) ? longint'(ua) - 2 * half : longint'(ua);
        sb   = (longint'(ub) >= half) ? longint'(ub) - 2 * half : longint'(ub);
        amt  = int'(ub % longint'(w));
        r = 64'd0; p = 64'd0; legal = 1'b1;
        case (op)
            4'b0000: r = ua & ub;
            4'b0001: r = ua | ub;
            4'b0010: r = ua ^ ub;
            4'b0011: begin
                r = ua + ub; e.c = r[w];
                t = sa + sb; e.v = (t >= half) || (t < -half);
            end
            4'b0100: begin
                r = ua - ub; e.c = (ua >= ub);
                t = sa - sb; e.v = (t >= half) || (t < -half);
            end
            4'b0101: begin e.s = (sa < sb); r = {63'd0, e.s}; end
            4'b0110: begin e.s = (ua < ub); r = {63'd0, e.s}; end
            4'b1001: r = ua << amt;
            4'b1010: r = ua >> amt;
            4'b1011: r = longint'(sa >>> amt);
            4'b1100: begin
                p = ua * ub; r = p;
                e.hi = 32'(p >> w); e.v = (e.hi != 32'd0);
            end
            4'b1101: begin
                if (ub == 64'd0) begin
                    r = m; e.hi = 32'(ua); e.v = 1'b1;
                end else begin
                    r = ua / ub; e.hi = 32'(ua % ub);
                end
            end
            default: legal = 1'b0;
        endcase
        r = r & m;
        e.res = r[31:0];
        e.z   = legal && (r == 64'd0);
        e.lat = (op == OP_MULU || op == OP_DIVU) ? w + 1 : 1;
        return e;
    endfunction

    function automatic logic [31:0] rnd(input int w);
        logic [31:0] m, msb;
        m   = (w == 32) ? 32'hffffffff : ((32'd1 << w) - 32'd1);
        msb = 32'd1 << (w - 1);
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return m;
            2: return msb;
            3: return msb - 32'd1;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom() & m;
        endcase
    endfunction

    // Called just after a negedge; waits for In_ready, presents the op for one edge.
    task automatic send(input int d, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e);
        int n;
        n = 0;
        while ((d == 0) ? !rdy32 : !rdy8) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                $display("FAIL handshake%0d: In_ready got 0 for 200 cycles, want 1", d);
                $fatal(1, "handshake timeout");
            end
        end
        e.acc = cyc;
        if (d == 0) begin
            a32 = a; b32 = b; op32 = op; v32 = 1'b1; sb32.push_back(e);
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; op8 = op; v8 = 1'b1; sb8.push_back(e);
        end
        @(negedge clk);
        if (d == 0) v32 = 1'b0; else v8 = 1'b0;
    endtask

    task automatic issue(input int d, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        send(d, op, a, b, model((d == 0) ? 32 : 8, op, a, b));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb32.size() != 0 || sb8.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                $display("FAIL drain: %0d/%0d responses outstanding, want 0/0", sb32.size(), sb8.size());
                $fatal(1, "drain timeout");
            end
        end
    endtask

    // Monitor: all counted comparisons live here.
    always @(negedge clk) begin
        now32 = {r32, h32, c32, o32, z32, s32};
        now8  = {r8, h8, c8, o8, z8, s8};
        if (chk_reset32) begin
            compared++;
            if (rdy32 !== 1'b1 || ov32 !== 1'b0 || now32 !== 68'd0) begin
                mismatched++;
                $display("FAIL reset32: rdy=%b ov=%b outs=%h, want rdy=1 ov=0 outs=0", rdy32, ov32, now32);
            end
        end
        if (chk_reset8) begin
            compared++;
            if (rdy8 !== 1'b1 || ov8 !== 1'b0 || now8 !== 20'd0) begin
                mismatched++;
                $display("FAIL reset8: rdy=%b ov=%b outs=%h, want rdy=1 ov=0 outs=0", rdy8, ov8, now8);
            end
        end
        if (chk_busy32) begin
            compared++;
            if (rdy32 !== 1'b0) begin
                mismatched++;
                $display("FAIL busy_ready32: In_ready=%b at cycle %0d, want 0", rdy32, cyc);
            end
        end
        if (rst32) begin
            last32 = 68'd0;
        end else if (ov32 === 1'b1) begin
            compared++;
            if (sb32.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected32: Out_valid=1 at cycle %0d, want no response", cyc);
            end else begin
                me = sb32.pop_front();
                want32 = {me.res, me.hi, me.c, me.v, me.z, me.s};
                ntx++;
                $display("txn32 #%0d Result=%h ResultHi=%h C=%b V=%b Z=%b S=%b lat=%0d",
                         ntx, r32, h32, c32, o32, z32, s32, cyc - me.acc);
                if (now32 !== want32) begin
                    mismatched++;
                    $display("FAIL result32: got R=%h H=%h CVZS=%b%b%b%b, want R=%h H=%h CVZS=%b%b%b%b",
                             r32, h32, c32, o32, z32, s32, me.res, me.hi, me.c, me.v, me.z, me.s);
                end
                compared++;
                if (cyc - me.acc != me.lat) begin
                    mismatched++;
                    $display("FAIL latency32: got %0d, want %0d", cyc - me.acc, me.lat);
                end
            end
            last32 = now32;
        end else begin
            compared++;
            if (now32 !== last32) begin
                mismatched++;
                $display("FAIL hold32: outputs %h changed without Out_valid, want %h", now32, last32);
            end
        end
        if (rst8) begin
            last8 = 20'd0;
        end else if (ov8 === 1'b1) begin
            compared++;
            if (sb8.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected8: Out_valid=1 at cycle %0d, want no response", cyc);
            end else begin
                me = sb8.pop_front();
                want8 = {me.res[7:0], me.hi[7:0], me.c, me.v, me.z, me.s};
                ntx++;
                $display("txn8 #%0d Result=%h ResultHi=%h C=%b V=%b Z=%b S=%b lat=%0d",
                         ntx, r8, h8, c8, o8, z8, s8, cyc - me.acc);
                if (now8 !== want8) begin
                    mismatched++;
                    $display("FAIL result8: got R=%h H=%h CVZS=%b%b%b%b, want R=%h H=%h CVZS=%b%b%b%b",
                             r8, h8, c8, o8, z8, s8, me.res[7:0], me.hi[7:0], me.c, me.v, me.z, me.s);
                end
                compared++;
                if (cyc - me.acc != me.lat) begin
                    mismatched++;
                    $display("FAIL latency8: got %0d, want %0d", cyc - me.acc, me.lat);
                end
            end
            last8 = now8;
        end else begin
            compared++;
            if (now8 !== last8) begin
                mismatched++;
                $display("FAIL hold8: outputs %h changed without Out_valid, want %h", now8, last8);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t reached without finishing, want earlier finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst32 = 1'b1; rst8 = 1'b1; v32 = 1'b0; v8 = 1'b0;
        a32 = '0; b32 = '0; op32 = '0; a8 = '0; b8 = '0; op8 = '0;
        chk_reset32 = 1'b1; chk_reset8 = 1'b1; chk_busy32 = 1'b0;
        last32 = '0; last8 = '0;
        repeat (3) @(negedge clk);
        #1;
        rst32 = 1'b0; rst8 = 1'b0; chk_reset32 = 1'b0; chk_reset8 = 1'b0;
        @(negedge clk);

        send(0, OP_ADD,  32'h0000003f, 32'h7fffffff, mk(32'h8000003e, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1));
        send(0, OP_SUB,  32'h8fffffff, 32'h80000000, mk(32'h0fffffff, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1));
        send(0, OP_SLTU, 32'h80000001, 32'h80000001, mk(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1));
        send(0, OP_SLT,  32'hffffffff, 32'h00000001, mk(32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1));
        send(0, OP_SLL,  32'haaaaaaaa, 32'h00000026, mk(32'haaaaaa80, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        send(0, OP_SRL,  32'haaaaaaaa, 32'h00000006, mk(32'h02aaaaaa, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        send(0, OP_SRA,  32'haaaaaaaa, 32'h00000006, mk(32'hfeaaaaaa, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        send(0, OP_SLL,  32'hfffffffa, 32'h0000001f, mk(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1));
        send(0, 4'b0111, 32'h00000005, 32'h00000005, mk(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1));

        // MULU: In_ready must stay low until Out_valid; a mid-op In_valid is ignored.
        send(0, OP_MULU, 32'hffffffff, 32'h00000002, mk(32'hfffffffe, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0, 33));
        #1 chk_busy32 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i == 3) begin a32 = 32'd1; b32 = 32'd1; op32 = OP_ADD; v32 = 1'b1; end
            if (i == 8) v32 = 1'b0;
        end
        #1 chk_busy32 = 1'b0;

        send(0, OP_DIVU, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 33));
        send(0, OP_DIVU, 32'd5,   32'd0, mk(32'hffffffff, 32'd5, 1'b0, 1'b1, 1'b0, 1'b0, 33));
        drain();

        // Reset at busy cycle 10 of a MULU: abort, clear outputs, no response.
        send(0, OP_MULU, 32'h00001234, 32'h00005678, model(32, OP_MULU, 32'h1234, 32'h5678));
        repeat (9) @(negedge clk);
        #1 rst32 = 1'b1; chk_reset32 = 1'b1;
        @(negedge clk);
        #1 rst32 = 1'b0; chk_reset32 = 1'b0;
        me = sb32.pop_back();
        repeat (40) @(negedge clk);

        for (int i = 0; i < 200; i++)
            issue(0, 4'($urandom_range(0, 15)), rnd(32), rnd(32));
        drain();

        send(1, OP_ADD,  32'h7f, 32'h01, mk(32'h80, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1));
        send(1, OP_MULU, 32'hff, 32'h02, mk(32'hfe, 32'h01, 1'b0, 1'b1, 1'b0, 1'b0, 9));
        send(1, OP_DIVU, 32'hc8, 32'h00, mk(32'hff, 32'hc8, 1'b0, 1'b1, 1'b0, 1'b0, 9));
        for (int i = 0; i < 80; i++)
            issue(1, 4'($urandom_range(0, 15)), rnd(8), rnd(8));
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
